multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Sequences one WIDTH-bit add/subtract datapath across a multi-precision operand of 1..MAX_WORDS words.
- Operands stream in least-significant word first over a valid/ready handshake.
- Chains the carry between words and streams sum words out.
- On the final word, reports carry-out and overflow; overflow is signed or unsigned as selected at start.
- Sits between an operand source (register file/DMA) and a result sink, and is the control wrapper around the carry-select adder core.

Parameters:
- WIDTH, 16, bits per operand/sum word.
- MAX_WORDS, 8, maximum words per operation.
- NW_W, 4, width of num_words; must satisfy 2**NW_W > MAX_WORDS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- num_words  input  NW_W  word count, sampled with start.
- signed_mode  input  1  1 = two's-complement overflow rule, 0 = unsigned; sampled with start.
- sub  input  1  1 = A-B, 0 = A+B; sampled with start.
- in_valid  input  1  a_word/b_word valid.
- in_ready  output  1  sequencer accepts the word pair this cycle.
- a_word  input  WIDTH  operand A word.
- b_word  input  WIDTH  operand B word.
- out_valid  output  1  sum_word valid.
- out_ready  input  1  sink accepts sum_word.
- sum_word  output  WIDTH  result word.
- out_last  output  1  sum_word is the most-significant word.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the operation completes.
- carry_out  output  1  final raw carry out of MSB; held until next start.
- overflow  output  1  overflow flag; held until next start.
- err  output  1  one-cycle pulse on illegal num_words.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: in_ready, out_valid, sum_word, out_last, busy, done, carry_out, overflow, err. Word counter and carry register also 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN, when start=1 and 1 <= num_words <= MAX_WORDS:
  - latch num_words, signed_mode, sub;
  - carry register = sub; counter = 0;
  - clear carry_out and overflow; busy=1 from the next cycle.
- IDLE, illegal start (num_words=0 or >MAX_WORDS): err=1 for one cycle; stay in IDLE; busy stays 0.
- start outside IDLE is ignored.
- RUN handshake: in_ready = !out_valid || out_ready (single output register, full throughput).
- RUN accept (in_valid && in_ready):
  - b' = b_word XOR {WIDTH{sub}}.
  - {c, s} = a_word + b' + carry, computed WIDTH+1 bits wide.
  - Next cycle: sum_word = s, out_valid = 1, out_last = (counter == num_words-1).
  - carry <= c; counter <= counter+1.
- Output hold: while out_valid && !out_ready, sum_word and out_last are stable and in_ready=0.
- Output pop: when out_ready=1 and no new accept in the same cycle, out_valid falls.
- Last-word accept:
  - carry_out <= c.
  - overflow <= signed_mode ? (a_msb == b'_msb) && (s_msb != a_msb) : (sub ? !c : c).
  - State -> DRAIN; in_ready=0 from the next cycle.
- DRAIN: wait for out_valid && out_ready (last word consumed), then -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE. carry_out and overflow hold their values.
- Latency: sum_word appears 1 cycle after its input is accepted. done asserts 1 cycle after the last output handshake.
- Carry wrap: the counter never exceeds num_words; extra in_valid after the last word is not accepted (in_ready=0).
- Single-word operation (num_words=1): the first accept is also the last; out_last=1 on the only output.
- Reset mid-operation: immediate return to IDLE with all outputs 0; any partially streamed result is discarded.

Test Plan:
- Unsigned add, 1 word: 0xFFFF + 0x0001 -> sum_word 0x0000, out_last=1, carry_out=1, overflow=1, done pulse 1 cycle after output handshake.
- Signed add, 2 words: A words {0xFFFF, 0x7FFF}, B words {0x0001, 0x0000} -> outputs 0x0000 then 0x8000 (out_last on second), carry_out=0, overflow=1.
- Subtract, 1 word, 0x0000 - 0x0001 -> sum 0xFFFF, carry_out=0. With signed_mode=1: overflow=0. With signed_mode=0: overflow=1 (borrow).
- Backpressure, 4-word add with out_ready held low 3 cycles after the 2nd output -> in_ready=0 and sum_word stable during the stall; all 4 words delivered in order, correct carry chain (e.g. 0x0000_FFFF_FFFF_FFFF + 1 -> 0x0001_0000_0000_0000).
- Illegal and ignored starts: num_words=0 -> err pulse, busy=0, no outputs. num_words=9 -> same. start asserted during RUN -> no effect on the current operation.
- Async reset asserted while RUN with 1 of 3 words output -> all outputs 0 immediately, state IDLE. A following legal start runs correctly from scratch.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams LS-word-first operand pairs through
// one WIDTH-bit adder, chaining carry between words and reporting carry/overflow at the end.
module multiword_add_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 8,
  parameter int NW_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW_W-1:0]  num_words,
  input  logic             signed_mode,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             overflow,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [NW_W-1:0]  count;
  logic [NW_W-1:0]  nw;
  logic             sgn;
  logic             sub_r;
  logic             carry;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             accept;
  logic             is_last;
  logic             legal;
  logic             ovf_next;

  // One output register: a new word may enter whenever the register is empty or draining.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Subtraction is A + ~B + 1, with the +1 coming from the carry seeded at start.
  assign b_eff   = b_word ^ {WIDTH{sub_r}};
  assign full    = {1'b0, a_word} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry};
  assign is_last = (count == (nw - NW_W'(1)));
  assign legal   = (num_words != '0) && (num_words <= NW_W'(MAX_WORDS));

  // For subtraction a missing carry means a borrow, i.e. unsigned underflow.
  assign ovf_next = sgn ? ((a_word[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a_word[WIDTH-1]))
                        : (sub_r ? !full[WIDTH] : full[WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      nw        <= '0;
      sgn       <= 1'b0;
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum_word  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              nw        <= num_words;
              sgn       <= signed_mode;
              sub_r     <= sub;
              carry     <= sub;
              count     <= '0;
              carry_out <= 1'b0;
              overflow  <= 1'b0;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            sum_word  <= full[WIDTH-1:0];
            out_valid <= 1'b1;
            out_last  <= is_last;
            carry     <= full[WIDTH];
            count     <= count + NW_W'(1);
            if (is_last) begin
              carry_out <= full[WIDTH];
              overflow  <= ovf_next;
              state     <= DRAIN;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed and randomized operations checked against
// a big-integer arithmetic model of the whole multi-word result.
module tb_multiword_add_sequencer;

  localparam int WIDTH     = 16;
  localparam int MAX_WORDS = 8;
  localparam int NW_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NW_W-1:0]  num_words;
  logic             signed_mode;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_word;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic             overflow;
  logic             err;

  multiword_add_sequencer #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .NW_W(NW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .signed_mode(signed_mode), .sub(sub), .in_valid(in_valid), .in_ready(in_ready),
    .a_word(a_word), .b_word(b_word), .out_valid(out_valid), .out_ready(out_ready),
    .sum_word(sum_word), .out_last(out_last), .busy(busy), .done(done),
    .carry_out(carry_out), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]  got_words [8];
  logic         got_last  [8];
  int           got_n;
  logic         got_co, got_ov;
  bit           done_ok, busy_ok, timeout;
  int           stall_bad, extra_bad;

  logic [127:0] exp_r;
  logic         exp_co, exp_ov;

  // Whole-operand arithmetic: n-bit integers, raw carry, and range-based overflow.
  function automatic void model(input int nw, input bit sgn, input bit sb,
                                input logic [127:0] a, input logic [127:0] b,
                                output logic [127:0] r_out, output logic co, output logic ov);
    logic [129:0]        ua, ub, r, mask;
    logic signed [129:0] sa, sbv, rs, lim;
    logic                ov_u;
    int                  n;
    n    = nw * 16;
    mask = (130'd1 << n) - 130'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    if (!sb) begin
      r    = ua + ub;
      co   = r[n];
      ov_u = co;
    end else begin
      r    = ua - ub;
      co   = (ua >= ub);
      ov_u = (ua < ub);
    end
    sa  = $signed(ua);
    if (ua[n-1]) sa = sa - $signed(mask + 130'd1);
    sbv = $signed(ub);
    if (ub[n-1]) sbv = sbv - $signed(mask + 130'd1);
    rs  = sb ? (sa - sbv) : (sa + sbv);
    lim = $signed(130'd1 << (n - 1));
    ov  = sgn ? ((rs >= lim) || (rs < -lim)) : ov_u;
    r   = r & mask;
    r_out = r[127:0];
  endfunction

  // Drives one operation cycle by cycle and records what the DUT produced.
  task automatic run_op(input int nw, input bit sgn, input bit sb,
                        input logic [127:0] a, input logic [127:0] b,
                        input int stall_after, input int stall_len, input bit rnd,
                        input int abort_after, input bit glitch);
    int          cyc, idx, outs, last_hs, stall_cnt;
    logic [15:0] prev_sum;
    bit          prev_stall, stalled_now, done_seen;
    cyc = 0; idx = 0; outs = 0; last_hs = -10; stall_cnt = 0;
    prev_sum = '0; prev_stall = 0; done_seen = 0;
    done_ok = 0; busy_ok = 0; timeout = 0; stall_bad = 0; extra_bad = 0;
    got_co = 1'bx; got_ov = 1'bx;
    for (int k = 0; k < 8; k++) begin
      got_words[k] = 'x;
      got_last[k]  = 1'bx;
    end
    @(negedge clk);
    start = 1'b1; num_words = nw[NW_W-1:0]; signed_mode = sgn; sub = sb;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    while (cyc < 300) begin
      if (done === 1'b1) begin
        done_seen = 1;
        done_ok = (outs == nw) && (last_hs == cyc - 1) && (busy === 1'b0);
        got_co = carry_out;
        got_ov = overflow;
        break;
      end
      if (abort_after >= 0 && outs >= abort_after) break;
      start = glitch && (cyc == 1);
      if (glitch) begin
        num_words = 4'd1; signed_mode = ~sgn; sub = ~sb;
      end
      if (outs == stall_after && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (idx >= nw) begin
        in_valid = 1'b1;
        a_word = 16'($urandom);
        b_word = 16'($urandom);
      end else begin
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        a_word = a[idx*16 +: 16];
        b_word = b[idx*16 +: 16];
      end
      #1;
      stalled_now = (out_valid === 1'b1) && !out_ready;
      if (stalled_now) begin
        if (in_ready !== 1'b0) stall_bad++;
        if (prev_stall && sum_word !== prev_sum) stall_bad++;
        prev_sum = sum_word;
      end
      prev_stall = stalled_now;
      if (in_valid && in_ready === 1'b1) begin
        if (idx >= nw) extra_bad++;
        else idx++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (outs < 8) begin
          got_words[outs] = sum_word;
          got_last[outs]  = out_last;
        end
        outs++;
        last_hs = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    got_n = outs;
    if (abort_after < 0) begin
      timeout = !done_seen;
      @(negedge clk);
      if (done !== 1'b0) done_ok = 0;
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    obs = {in_ready, out_valid, sum_word, out_last, busy, done, carry_out, overflow, err};
    n_cmp++;
    if (obs !== 24'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 24'h0);
    end
  endtask

  task automatic test_directed();
    int           t_nw  [4];
    bit           t_sgn [4];
    bit           t_sb  [4];
    logic [127:0] t_a   [4];
    logic [127:0] t_b   [4];
    t_nw  = '{1, 2, 1, 1};
    t_sgn = '{0, 1, 1, 0};
    t_sb  = '{0, 0, 1, 1};
    t_a   = '{128'hFFFF, 128'h7FFF_FFFF, 128'h0, 128'h0};
    t_b   = '{128'h0001, 128'h0000_0001, 128'h1, 128'h1};
    for (int i = 0; i < 4; i++) begin
      model(t_nw[i], t_sgn[i], t_sb[i], t_a[i], t_b[i], exp_r, exp_co, exp_ov);
      run_op(t_nw[i], t_sgn[i], t_sb[i], t_a[i], t_b[i], -1, 0, 0, -1, 0);
      n_cmp++;
      if (got_n !== t_nw[i] || timeout) begin
        n_bad++;
        $display("[TB] FAIL dir%0d_count: got %0d words (timeout=%0d) expected %0d", i, got_n, timeout, t_nw[i]);
      end
      for (int k = 0; k < t_nw[i]; k++) begin
        n_cmp++;
        if (got_words[k] !== exp_r[k*16 +: 16] || got_last[k] !== (k == t_nw[i] - 1)) begin
          n_bad++;
          $display("[TB] FAIL dir%0d_word%0d: got %h last=%b expected %h last=%b", i, k,
                   got_words[k], got_last[k], exp_r[k*16 +: 16], (k == t_nw[i] - 1));
        end
      end
      n_cmp++;
      if ({got_co, got_ov} !== {exp_co, exp_ov}) begin
        n_bad++;
        $display("[TB] FAIL dir%0d_flags: got co=%b ov=%b expected co=%b ov=%b", i, got_co, got_ov, exp_co, exp_ov);
      end
      n_cmp++;
      if (!(done_ok && busy_ok)) begin
        n_bad++;
        $display("[TB] FAIL dir%0d_done_busy: got done_ok=%0d busy_ok=%0d expected 1 1", i, done_ok, busy_ok);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b;
    a = 128'h0000_FFFF_FFFF_FFFF;
    b = 128'h1;
    model(4, 0, 0, a, b, exp_r, exp_co, exp_ov);
    run_op(4, 0, 0, a, b, 2, 3, 0, -1, 0);
    n_cmp++;
    if (stall_bad != 0 || extra_bad != 0) begin
      n_bad++;
      $display("[TB] FAIL bp_stall: got %0d stall and %0d extra violations expected 0", stall_bad, extra_bad);
    end
    n_cmp++;
    if (got_n !== 4 || {got_words[3], got_words[2], got_words[1], got_words[0]} !== exp_r[63:0]) begin
      n_bad++;
      $display("[TB] FAIL bp_words: got %0d words %h_%h_%h_%h expected %h", got_n,
               got_words[3], got_words[2], got_words[1], got_words[0], exp_r[63:0]);
    end
    n_cmp++;
    if ({got_co, got_ov, done_ok} !== {exp_co, exp_ov, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL bp_flags: got co=%b ov=%b done_ok=%0d expected co=%b ov=%b done_ok=1",
               got_co, got_ov, done_ok, exp_co, exp_ov);
    end
  endtask

  task automatic test_illegal();
    int bad_nw [2];
    bad_nw = '{0, 9};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1; num_words = bad_nw[i][NW_W-1:0]; signed_mode = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({err, busy, out_valid, in_ready} !== 4'b1000) begin
        n_bad++;
        $display("[TB] FAIL illegal_nw%0d_pulse: got err,busy,ov,ir=%b expected 1000", bad_nw[i], {err, busy, out_valid, in_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({err, busy, out_valid, in_ready} !== 4'b0000) begin
        n_bad++;
        $display("[TB] FAIL illegal_nw%0d_after: got err,busy,ov,ir=%b expected 0000", bad_nw[i], {err, busy, out_valid, in_ready});
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [127:0] a, b;
    a = {80'h0, 16'h8001, 16'h1234, 16'hFFFF};
    b = {80'h0, 16'h7FFE, 16'h0F0F, 16'h0001};
    model(3, 0, 0, a, b, exp_r, exp_co, exp_ov);
    run_op(3, 0, 0, a, b, -1, 0, 0, -1, 1);
    n_cmp++;
    if (got_n !== 3 || {got_words[2], got_words[1], got_words[0]} !== exp_r[47:0] || got_last[2] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL start_in_run_words: got %0d words %h_%h_%h expected %h", got_n,
               got_words[2], got_words[1], got_words[0], exp_r[47:0]);
    end
    n_cmp++;
    if ({got_co, got_ov, done_ok} !== {exp_co, exp_ov, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL start_in_run_flags: got co=%b ov=%b done_ok=%0d expected co=%b ov=%b done_ok=1",
               got_co, got_ov, done_ok, exp_co, exp_ov);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] a, b;
    logic [23:0]  obs;
    a = {80'h0, 16'h1111, 16'h2222, 16'hFFFF};
    b = {80'h0, 16'h0001, 16'h0002, 16'h0003};
    run_op(3, 0, 0, a, b, -1, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {in_ready, out_valid, sum_word, out_last, busy, done, carry_out, overflow, err};
    n_cmp++;
    if (obs !== 24'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_run: got %h expected %h", obs, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(3, 1, 1, a, b, exp_r, exp_co, exp_ov);
    run_op(3, 1, 1, a, b, -1, 0, 0, -1, 0);
    n_cmp++;
    if (got_n !== 3 || {got_words[2], got_words[1], got_words[0]} !== exp_r[47:0] ||
        {got_co, got_ov, done_ok} !== {exp_co, exp_ov, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL after_reset_op: got %0d words %h_%h_%h co=%b ov=%b done_ok=%0d expected %h co=%b ov=%b",
               got_n, got_words[2], got_words[1], got_words[0], got_co, got_ov, done_ok, exp_r[47:0], exp_co, exp_ov);
    end
  endtask

  task automatic test_random();
    logic [127:0] a, b;
    int           nw;
    bit           sgn, sb;
    for (int i = 0; i < 30; i++) begin
      nw  = $urandom_range(1, MAX_WORDS);
      sgn = 1'($urandom);
      sb  = 1'($urandom);
      a   = {$urandom, $urandom, $urandom, $urandom};
      b   = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = sb ? a : ~a;
      if ($urandom_range(0, 3) == 0) a[nw*16-1 -: 16] = 16'h7FFF;
      model(nw, sgn, sb, a, b, exp_r, exp_co, exp_ov);
      run_op(nw, sgn, sb, a, b, $urandom_range(0, 3), $urandom_range(0, 4), 1, -1, 0);
      n_cmp++;
      if (got_n !== nw || timeout || stall_bad != 0 || extra_bad != 0) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_flow: got %0d words timeout=%0d stall=%0d extra=%0d expected %0d words, no violations",
                 i, got_n, timeout, stall_bad, extra_bad, nw);
      end
      for (int k = 0; k < nw; k++) begin
        n_cmp++;
        if (got_words[k] !== exp_r[k*16 +: 16] || got_last[k] !== (k == nw - 1)) begin
          n_bad++;
          $display("[TB] FAIL rnd%0d_word%0d: got %h last=%b expected %h last=%b", i, k,
                   got_words[k], got_last[k], exp_r[k*16 +: 16], (k == nw - 1));
        end
      end
      n_cmp++;
      if ({got_co, got_ov, done_ok, busy_ok} !== {exp_co, exp_ov, 1'b1, 1'b1}) begin
        n_bad++;
        $display("[TB] FAIL rnd%0d_flags: got co=%b ov=%b done_ok=%0d busy_ok=%0d expected co=%b ov=%b 1 1",
                 i, got_co, got_ov, done_ok, busy_ok, exp_co, exp_ov);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_words = '0; signed_mode = 1'b0; sub = 1'b0;
    in_valid = 1'b0; a_word = '0; b_word = '0; out_ready = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_backpressure();
    test_illegal();
    test_start_during_run();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
